// File: rtl/pipemem_stage.sv
// MEM stage: little-endian byte/half/word data RAM with a wait-state FSM that stalls upstream.
// Optional misaligned-access detection is enabled by defining MEM_ALIGN_CHECK_EN.
module pipemem_stage #(
    parameter int DEPTH       = 1024,
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        mwreg,
    input  logic        mm2reg,
    input  logic        mwmem,
    input  logic [1:0]  msize,
    input  logic        msext,
    input  logic [31:0] malu,
    input  logic [31:0] mb,
    input  logic [4:0]  mrn,
    output logic [31:0] mmo,
    output logic [31:0] malu_o,
    output logic [4:0]  mrn_o,
    output logic        mwreg_o,
    output logic        mm2reg_o,
    output logic        mstall,
    output logic        mexc
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam bit HAS_WAIT = (WAIT_CYCLES > 0);

    state_t            state;
    logic [3:0]        cnt;
    logic              acc;
    logic              exc;
    logic              we;
    logic [ADDR_W-1:0] idx;
    logic [1:0]        lane;
    logic [3:0]        wmask;
    logic [31:0]       wdata;
    logic [31:0]       rword;
    logic [31:0]       ldata;
    logic [31:0]       mem [DEPTH];

    assign acc  = mm2reg | mwmem;
    assign idx  = malu[ADDR_W+1:2];
    assign lane = malu[1:0];

`ifdef MEM_ALIGN_CHECK_EN
    assign exc = ((msize == 2'b01) & lane[0]) | (msize[1] & (lane != 2'b00));
`else
    assign exc = 1'b0;
`endif

    // The IDLE cycle is the first stall cycle, so BUSY only covers the remaining
    // WAIT_CYCLES-1; cnt holds the number of BUSY cycles still to go after this one.
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (acc && HAS_WAIT) begin
                        if (WAIT_CYCLES > 1) begin
                            state <= BUSY;
                            cnt   <= 4'(WAIT_CYCLES - 2);
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) state <= DONE;
                    else             cnt   <= cnt - 4'd1;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign mstall = ~clrn & (((state == IDLE) & acc & HAS_WAIT) | (state == BUSY));

    // Write only in the single non-stalled cycle, so a store lands exactly once.
    assign we = ~clrn & mwmem & ~exc &
                ((state == DONE) | ((state == IDLE) & ~HAS_WAIT));

    always_comb begin
        wmask = 4'b1111;
        wdata = mb;
        case (msize)
            2'b00: begin
                wmask = 4'b0001 << lane;
                wdata = {4{mb[7:0]}};
            end
            2'b01: begin
                wmask = lane[1] ? 4'b1100 : 4'b0011;
                wdata = {2{mb[15:0]}};
            end
            default: ;
        endcase
    end

    // NOTE: the RAM has no reset branch; clearing 1024 words is neither required
    // nor cheap, so it lives in its own clocked block outside the async-reset FSM.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rword = mem[idx];

    always_comb begin
        ldata = rword;
        case (msize)
            2'b00: begin
                ldata[7:0]  = rword[8*lane +: 8];
                ldata[31:8] = {24{msext & ldata[7]}};
            end
            2'b01: begin
                ldata[15:0]  = lane[1] ? rword[31:16] : rword[15:0];
                ldata[31:16] = {16{msext & ldata[15]}};
            end
            default: ;
        endcase
    end

    assign mmo      = (~clrn & mm2reg & ~exc) ? ldata : 32'd0;
    assign malu_o   = clrn ? 32'd0 : malu;
    assign mrn_o    = clrn ? 5'd0 : mrn;
    assign mwreg_o  = ~clrn & mwreg & ~exc;
    assign mm2reg_o = ~clrn & mm2reg;
    assign mexc     = ~clrn & exc;

endmodule

// File: tb/tb_pipemem_stage.sv
// Directed bench for pipemem_stage: one instance with WAIT_CYCLES=2, one with WAIT_CYCLES=0.
// Expectations for the misaligned cases follow MEM_ALIGN_CHECK_EN when it is defined.
module tb_pipemem_stage;

    logic        clk = 1'b0;
    logic        clrn;
    logic        mwreg, mm2reg, mwmem, msext;
    logic [1:0]  msize;
    logic [31:0] malu, mb;
    logic [4:0]  mrn;
    logic [31:0] mmo, malu_o;
    logic [4:0]  mrn_o;
    logic        mwreg_o, mm2reg_o, mstall, mexc;

    logic        z_mwreg, z_mm2reg, z_mwmem, z_msext;
    logic [1:0]  z_msize;
    logic [31:0] z_malu, z_mb;
    logic [4:0]  z_mrn;
    logic [31:0] z_mmo, z_malu_o;
    logic [4:0]  z_mrn_o;
    logic        z_mwreg_o, z_mm2reg_o, z_mstall, z_mexc;

    int          checks   = 0;
    int          failures = 0;
    int          stalls;
    logic [31:0] rd;
    logic        obs_exc, obs_wreg;

    always #5 clk = ~clk;

    pipemem_stage #(.DEPTH(1024), .ADDR_W(10), .WAIT_CYCLES(2)) u_dut (
        .clk(clk), .clrn(clrn), .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
        .msize(msize), .msext(msext), .malu(malu), .mb(mb), .mrn(mrn),
        .mmo(mmo), .malu_o(malu_o), .mrn_o(mrn_o), .mwreg_o(mwreg_o),
        .mm2reg_o(mm2reg_o), .mstall(mstall), .mexc(mexc)
    );

    pipemem_stage #(.DEPTH(1024), .ADDR_W(10), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .clrn(clrn), .mwreg(z_mwreg), .mm2reg(z_mm2reg), .mwmem(z_mwmem),
        .msize(z_msize), .msext(z_msext), .malu(z_malu), .mb(z_mb), .mrn(z_mrn),
        .mmo(z_mmo), .malu_o(z_malu_o), .mrn_o(z_mrn_o), .mwreg_o(z_mwreg_o),
        .mm2reg_o(z_mm2reg_o), .mstall(z_mstall), .mexc(z_mexc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Presents one access right after a rising edge and walks it to completion.
    task automatic run_access(input logic ld, input logic st, input logic [1:0] sz,
                              input logic sx, input logic [31:0] addr, input logic [31:0] data);
        mm2reg = ld;
        mwreg  = ld;
        mwmem  = st;
        msize  = sz;
        msext  = sx;
        malu   = addr;
        mb     = data;
        mrn    = 5'd7;
        stalls = 0;
        @(negedge clk);
        while (mstall && stalls < 20) begin
            stalls++;
            @(negedge clk);
        end
        rd       = mmo;
        obs_exc  = mexc;
        obs_wreg = mwreg_o;
        @(posedge clk);
        #1;
        mm2reg = 1'b0;
        mwreg  = 1'b0;
        mwmem  = 1'b0;
    endtask

    initial begin
        clrn = 1'b1;
        mwreg = 1'b1; mm2reg = 1'b1; mwmem = 1'b0; msize = 2'b10; msext = 1'b0;
        malu = 32'h0000_0010; mb = 32'h1234_5678; mrn = 5'd5;
        z_mwreg = 1'b0; z_mm2reg = 1'b0; z_mwmem = 1'b0; z_msize = 2'b10;
        z_msext = 1'b0; z_malu = '0; z_mb = '0; z_mrn = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_mmo",      mmo,      32'd0);
        check("rst_malu_o",   malu_o,   32'd0);
        check("rst_mrn_o",    32'(mrn_o), 32'd0);
        check("rst_mwreg_o",  32'(mwreg_o), 32'd0);
        check("rst_mm2reg_o", 32'(mm2reg_o), 32'd0);
        check("rst_mstall",   32'(mstall), 32'd0);
        check("rst_mexc",     32'(mexc), 32'd0);
        mwreg = 1'b0; mm2reg = 1'b0;
        clrn = 1'b0;
        @(posedge clk);
        #1;

        run_access(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
        check("sw_stalls", 32'(stalls), 32'd2);
        run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        check("lw_10", rd, 32'hDEAD_BEEF);
        check("lw_stalls", 32'(stalls), 32'd2);

        run_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h13, 32'h1234_5680);
        run_access(1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
        check("lb_13", rd, 32'hFFFF_FF80);
        run_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
        check("lbu_13", rd, 32'h0000_0080);
        run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        check("lw_10_byte", rd, 32'h80AD_BEEF);
        run_access(1'b1, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
        check("lh_12", rd, 32'hFFFF_80AD);

        run_access(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h5566_7788);
        run_access(1'b0, 1'b1, 2'b01, 1'b0, 32'h22, 32'hABCD_1234);
        run_access(1'b1, 1'b0, 2'b01, 1'b1, 32'h22, 32'h0);
        check("lh_22", rd, 32'h0000_1234);
        run_access(1'b1, 1'b0, 2'b01, 1'b1, 32'h20, 32'h0);
        check("lh_20", rd, 32'h0000_7788);
        run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        check("lw_20", rd, 32'h1234_7788);

        // ALU instruction between two loads: pass-through, no stall.
        mwreg = 1'b1; mm2reg = 1'b0; mwmem = 1'b0; malu = 32'hCAFE_0004; mrn = 5'd9;
        @(negedge clk);
        check("alu_mstall",  32'(mstall), 32'd0);
        check("alu_mmo",     mmo, 32'd0);
        check("alu_malu_o",  malu_o, 32'hCAFE_0004);
        check("alu_mrn_o",   32'(mrn_o), 32'd9);
        check("alu_mwreg_o", 32'(mwreg_o), 32'd1);
        @(posedge clk);
        #1;
        run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        check("lw_after_alu_stalls", 32'(stalls), 32'd2);
        check("lw_wreg", 32'(obs_wreg), 32'd1);

        // Reset during BUSY of a store abandons it.
        mwmem = 1'b1; mm2reg = 1'b0; mwreg = 1'b0; msize = 2'b10;
        malu = 32'h10; mb = 32'h1111_1111;
        @(posedge clk);
        #1;
        check("busy_mstall", 32'(mstall), 32'd1);
        clrn = 1'b1;
        #1;
        check("midrst_mstall", 32'(mstall), 32'd0);
        check("midrst_malu_o", malu_o, 32'd0);
        check("midrst_mexc",   32'(mexc), 32'd0);
        @(posedge clk);
        #1;
        mwmem = 1'b0;
        clrn = 1'b0;
        run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        check("lw_after_rst", rd, 32'h80AD_BEEF);
        check("lw_after_rst_stalls", 32'(stalls), 32'd2);

`ifdef MEM_ALIGN_CHECK_EN
        run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h11, 32'h0);
        check("mis_lw_mexc",  32'(obs_exc), 32'd1);
        check("mis_lw_mmo",   rd, 32'd0);
        check("mis_lw_wreg",  32'(obs_wreg), 32'd0);
        check("mis_lw_stall", 32'(stalls), 32'd2);
        run_access(1'b0, 1'b1, 2'b10, 1'b0, 32'h12, 32'hAAAA_AAAA);
        run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        check("mis_sw_kept", rd, 32'h80AD_BEEF);
`else
        run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h11, 32'h0);
        check("mis_lw_forced", rd, 32'h80AD_BEEF);
        check("mis_lw_mexc",   32'(obs_exc), 32'd0);
        run_access(1'b1, 1'b0, 2'b01, 1'b0, 32'h23, 32'h0);
        check("mis_lh_forced", rd, 32'h0000_1234);
`endif

        // Zero-wait instance: no stalls and address wrap modulo DEPTH.
        z_mwmem = 1'b1; z_msize = 2'b10; z_malu = 32'h1010; z_mb = 32'hCAFE_F00D;
        @(negedge clk);
        check("w0_sw_mstall", 32'(z_mstall), 32'd0);
        @(posedge clk);
        #1;
        z_mwmem = 1'b0; z_mm2reg = 1'b1; z_mwreg = 1'b1; z_malu = 32'h0010;
        @(negedge clk);
        check("w0_lw_mstall", 32'(z_mstall), 32'd0);
        check("w0_alias",     z_mmo, 32'hCAFE_F00D);
        @(posedge clk);
        #1;
        z_mm2reg = 1'b0; z_mwreg = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
